// File: rtl/grasspopper_pkg.sv
// Shared widths and the adapter control states for the grasspopper stream adapter.
package grasspopper_pkg;
  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } adapter_state_t;
endpackage

// File: rtl/grasspopper_word_buf.sv
// Four-word block buffer: PACK=1 collects words into a block, PACK=0 emits a loaded block word by word.
module grasspopper_word_buf
  import grasspopper_pkg::*;
#(
  parameter bit PACK  = 1'b1,
  parameter int OUT_W = PACK ? BLOCK_W : WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_step,
  input  logic [WORD_W-1:0]  i_word,
  input  logic               i_load,
  input  logic [BLOCK_W-1:0] i_load_data,
  input  logic               i_clr,
  output logic [OUT_W-1:0]   o_data,
  output logic               o_full
);

  logic [BLOCK_W-1:0] r_buf;
  logic [IDX_W-1:0]   r_idx;
  logic               r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_load) begin
        r_buf  <= i_load_data;
        r_idx  <= '0;
        r_full <= 1'b1;
      end else if (i_step) begin
        // Unpack shifts right so the current output word always sits in the low slice.
        if (PACK) r_buf[int'(r_idx)*WORD_W +: WORD_W] <= i_word;
        else      r_buf <= {{WORD_W{1'b0}}, r_buf[BLOCK_W-1:WORD_W]};
        r_idx <= r_idx + 1'b1;
        if (r_idx == IDX_W'(WORDS_PER_BLOCK - 1)) r_full <= PACK;
      end
      if (i_clr) r_full <= 1'b0;
    end
  end

  assign o_data = r_buf[OUT_W-1:0];
  assign o_full = r_full;

endmodule

// File: rtl/grasspopper_stream_adapter.sv
// Packs a 32-bit stream into 128-bit blocks for the cipher core and unpacks its results
// back onto a 32-bit stream; input and output buffers are independent so they overlap.
module grasspopper_stream_adapter
  import grasspopper_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [WORD_W-1:0]  m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [BLOCK_W-1:0] core_data_o,
  output logic               core_req_o,
  output logic               core_ack_o,
  input  logic [BLOCK_W-1:0] core_data_i,
  input  logic               core_valid_i,
  input  logic               core_busy_i,
  input  logic               err_clr_i,
  output logic               err_timeout_o,
  output logic [CNT_W-1:0]   blk_cnt_o
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);

  adapter_state_t    r_state, w_next_state;
  logic [WDOG_W-1:0] r_wdog;
  logic [CNT_W-1:0]  r_blk_cnt;
  logic              r_err;
  logic              w_in_full, w_out_full;
  logic              w_in_accept, w_out_accept;
  logic              w_ack, w_timeout, w_stall;

  // Both streams: a beat transfers on the rising edge where valid and ready are both high.
  assign s_ready_o    = !w_in_full;
  assign w_in_accept  = s_valid_i && s_ready_o;
  assign m_valid_o    = w_out_full;
  assign w_out_accept = m_valid_o && m_ready_i;
  // Result is ready but the output buffer is still draining: hold off and freeze the watchdog.
  assign w_stall      = core_valid_i && w_out_full;

  always_comb begin
    w_next_state = r_state;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    core_req_o   = 1'b0;
    case (r_state)
      IDLE: if (w_in_full && !core_busy_i) w_next_state = REQ;
      REQ: begin
        core_req_o   = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (core_valid_i && !w_out_full) begin
          w_ack        = 1'b1;
          w_next_state = IDLE;
        end else if (!core_valid_i && r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wdog    <= '0;
      r_blk_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == REQ)                 r_wdog <= '0;
      else if (r_state == WAIT && !w_stall) r_wdog <= r_wdog + 1'b1;
      if (w_ack) r_blk_cnt <= r_blk_cnt + 1'b1;
      if (w_timeout)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign core_ack_o    = w_ack;
  assign blk_cnt_o     = r_blk_cnt;
  assign err_timeout_o = r_err;

  grasspopper_word_buf #(.PACK(1'b1)) u_in_buf (
    .clk         (clk),
    .rst         (rst),
    .i_step      (w_in_accept),
    .i_word      (s_data_i),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_clr       (w_ack || w_timeout),
    .o_data      (core_data_o),
    .o_full      (w_in_full)
  );

  grasspopper_word_buf #(.PACK(1'b0)) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_step      (w_out_accept),
    .i_word      ('0),
    .i_load      (w_ack),
    .i_load_data (core_data_i),
    .i_clr       (1'b0),
    .o_data      (m_data_o),
    .o_full      (w_out_full)
  );

endmodule
